// File: rtl/matrix_mul_fx_stream_if.sv
// rtl/matrix_mul_fx_stream_if.sv - host load/control port and result stream of the matrix multiplier
interface matrix_mul_fx_stream_if #(
    parameter int N         = 4,
    parameter int WORD_SIZE = 16,
    parameter int ADDRS_LEN = $clog2(2*N*N)
);
    logic                          we;
    logic [ADDRS_LEN-1:0]          addr;
    logic signed [WORD_SIZE-1:0]   data_wr;
    logic                          start;
    logic                          busy;
    logic                          done;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [WORD_SIZE-1:0]   out_data;
    logic [$clog2(N)-1:0]          out_row;
    logic [$clog2(N)-1:0]          out_col;
    logic                          ovf;

    modport master (
        output we, addr, data_wr, start, out_ready,
        input  busy, done, out_valid, out_data, out_row, out_col, ovf
    );

    modport slave (
        input  we, addr, data_wr, start, out_ready,
        output busy, done, out_valid, out_data, out_row, out_col, ovf
    );
endinterface

// File: rtl/matrix_mul_fx_stream.sv
// rtl/matrix_mul_fx_stream.sv - fixed-point NxN multiplier, one MAC, column-major rounded/saturated output stream
module matrix_mul_fx_stream #(
    parameter int N         = 4,
    parameter int WORD_SIZE = 16,
    parameter int QF_BITS   = 8,
    parameter int ADDRS_LEN = $clog2(2*N*N)
) (
    input  logic                  src_clk,
    input  logic                  rst_n,
    matrix_mul_fx_stream_if.slave bus,
    output logic [3:0]            QI,
    output logic [3:0]            QF
);
    localparam int NN   = N * N;
    localparam int AW   = $clog2(NN);
    localparam int IW   = $clog2(N);
    localparam int KW   = $clog2(N + 1);
    localparam int PW   = 2 * WORD_SIZE;
    localparam int ACCW = 2 * WORD_SIZE + $clog2(N);

    localparam logic [ADDRS_LEN:0] NN_E  = (ADDRS_LEN+1)'(NN);
    localparam logic [ADDRS_LEN:0] NN2_E = (ADDRS_LEN+1)'(2 * NN);
    localparam logic [KW-1:0]      K_END = KW'(N);
    localparam logic [IW-1:0]      I_END = IW'(N - 1);
    localparam logic signed [ACCW-1:0] RND     = ACCW'(1) << (QF_BITS - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MAC, ROUND, OUT, DONE} state_t;

    state_t state, next_state;

    logic signed [WORD_SIZE-1:0] mem_a [NN];
    logic signed [WORD_SIZE-1:0] mem_b [NN];
    logic signed [WORD_SIZE-1:0] rd_a, rd_b;

    logic [ADDRS_LEN:0]     addr_ext;
    logic [AW-1:0]          wr_a_idx, wr_b_idx, a_idx, b_idx;
    logic                   wr_ok, rd_en, last_elem, sat_hi, sat_lo;
    logic [KW-1:0]          k;
    logic [IW-1:0]          i, j;
    logic                   prod_vld;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc, prod_ext, rsum, rsh;
    logic signed [WORD_SIZE-1:0] rnd_val, out_data;
    logic [IW-1:0]          out_row, out_col;
    logic                   ovf, busy, done, out_valid;

    assign QI = 4'(WORD_SIZE - QF_BITS);
    assign QF = 4'(QF_BITS);

    assign addr_ext = {1'b0, bus.addr};
    assign wr_a_idx = AW'(addr_ext);
    assign wr_b_idx = AW'(addr_ext - NN_E);
    assign wr_ok    = bus.we && (state == IDLE);

    assign rd_en     = (state == MAC) && (k < K_END);
    assign a_idx     = AW'(i) * AW'(N) + AW'(k);
    assign b_idx     = AW'(k) * AW'(N) + AW'(j);
    assign last_elem = (i == I_END) && (j == I_END);

    // Memory is deliberately left out of reset so a run can be repeated after an abort.
    always_ff @(posedge src_clk) begin
        if (wr_ok && (addr_ext < NN_E)) begin
            mem_a[wr_a_idx] <= bus.data_wr;
        end else if (wr_ok && (addr_ext < NN2_E)) begin
            mem_b[wr_b_idx] <= bus.data_wr;
        end
        if (rd_en) begin
            rd_a <= mem_a[a_idx];
            rd_b <= mem_b[b_idx];
        end
    end

    assign prod     = rd_a * rd_b;
    assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};

    // Round half up, then clamp to the signed output word range.
    assign rsum    = acc + RND;
    assign rsh     = rsum >>> QF_BITS;
    assign sat_hi  = rsh > SAT_MAX;
    assign sat_lo  = rsh < SAT_MIN;
    assign rnd_val = sat_hi ? SAT_MAX[WORD_SIZE-1:0] :
                     sat_lo ? SAT_MIN[WORD_SIZE-1:0] : rsh[WORD_SIZE-1:0];

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE:  if (bus.start) next_state = MAC;
            MAC: begin
                busy = 1'b1;
                if (k == K_END) next_state = ROUND;
            end
            ROUND: begin
                busy       = 1'b1;
                next_state = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) next_state = last_elem ? DONE : MAC;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            k        <= '0;
            i        <= '0;
            j        <= '0;
            prod_vld <= 1'b0;
            out_data <= '0;
            out_row  <= '0;
            out_col  <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc      <= '0;
                        k        <= '0;
                        i        <= '0;
                        j        <= '0;
                        prod_vld <= 1'b0;
                        ovf      <= 1'b0;
                    end
                end
                MAC: begin
                    // Product of the read issued last cycle lands now.
                    prod_vld <= rd_en;
                    if (prod_vld) acc <= acc + prod_ext;
                    k <= (k == K_END) ? '0 : k + KW'(1);
                end
                ROUND: begin
                    out_data <= rnd_val;
                    out_row  <= i;
                    out_col  <= j;
                    if (sat_hi || sat_lo) ovf <= 1'b1;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        acc      <= '0;
                        prod_vld <= 1'b0;
                        if (i == I_END) begin
                            i <= '0;
                            j <= j + IW'(1);
                        end else begin
                            i <= i + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_row   = out_row;
    assign bus.out_col   = out_col;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_matrix_mul_fx_stream.sv
// tb/tb_matrix_mul_fx_stream.sv - scoreboard bench for matrix_mul_fx_stream, N=2 Q8.8
module tb_matrix_mul_fx_stream;
    localparam int N  = 2;
    localparam int W  = 16;
    localparam int QB = 8;
    localparam int AL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_mul_fx_stream_if #(.N(N), .WORD_SIZE(W), .ADDRS_LEN(AL)) bus();
    logic [3:0] qi, qf;

    matrix_mul_fx_stream #(.N(N), .WORD_SIZE(W), .QF_BITS(QB), .ADDRS_LEN(AL)) dut (
        .src_clk(clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .QI     (qi),
        .QF     (qf)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct packed {
        int row;
        int col;
        int data;
    } beat_t;

    beat_t sb[$];
    int    ma[N*N];
    int    mb[N*N];

    function automatic int model(input int r, input int c, output bit sat);
        longint acc, q;
        acc = 0;
        for (int kk = 0; kk < N; kk++) acc += longint'(ma[r*N+kk]) * longint'(mb[kk*N+c]);
        q   = (acc + 128) >>> QB;
        sat = 1'b0;
        if (q > 32767)  begin q = 32767;  sat = 1'b1; end
        if (q < -32768) begin q = -32768; sat = 1'b1; end
        return int'(q);
    endfunction

    function automatic bit push_expected();
        bit any, s;
        beat_t b;
        any = 1'b0;
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < N; r++) begin
                b.row  = r;
                b.col  = c;
                b.data = model(r, c, s);
                any    = any | s;
                sb.push_back(b);
            end
        end
        return any;
    endfunction

    bit    held = 1'b0;
    beat_t hv;
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (!bus.out_ready) begin
                if (held) begin
                    check("hold_row",  bus.out_row, hv.row);
                    check("hold_col",  bus.out_col, hv.col);
                    check("hold_data", $signed(bus.out_data), hv.data);
                end
                held    = 1'b1;
                hv.row  = int'(bus.out_row);
                hv.col  = int'(bus.out_col);
                hv.data = int'($signed(bus.out_data));
            end else begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat_row",  bus.out_row, e.row);
                    check("beat_col",  bus.out_col, e.col);
                    check("beat_data", $signed(bus.out_data), e.data);
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    // All tasks start and end at posedge+1.
    task automatic wr(input int a, input int d);
        bus.we      = 1'b1;
        bus.addr    = AL'(a);
        bus.data_wr = W'(d);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        if (a < N*N) ma[a] = d;
        else if (a < 2*N*N) mb[a-N*N] = d;
    endtask

    task automatic load(input int a0, a1, a2, a3, b0, b1, b2, b3);
        wr(0, a0); wr(1, a1); wr(2, a2); wr(3, a3);
        wr(4, b0); wr(5, b1); wr(6, b2); wr(7, b3);
    endtask

    task automatic run(input int stall, input bit poke, input int reset_at);
        bit exp_ovf;
        int cyc, first, done_cyc, left;
        exp_ovf  = push_expected();
        first    = -1;
        done_cyc = -1;
        left     = 0;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) check("busy_running", bus.busy, 1);
            if (reset_at == cyc) begin
                check("ovf_pre_reset", bus.ovf, 1);
                #2 rst_n = 1'b0;
                #1;
                check("rst_busy", bus.busy, 0);
                check("rst_valid", bus.out_valid, 0);
                check("rst_ovf", bus.ovf, 0);
                check("rst_done", bus.done, 0);
                check("rst_row", bus.out_row, 0);
                check("rst_data", bus.out_data, 0);
                #13 rst_n = 1'b1;
                @(posedge clk);
                #1;
                sb.delete();
                return;
            end
            if (poke && cyc == 1) begin
                bus.we = 1'b1; bus.addr = AL'(0); bus.data_wr = W'(555);
            end
            if (poke && cyc == 2) begin
                bus.we = 1'b0; bus.start = 1'b1;
            end
            if (poke && cyc == 3) bus.start = 1'b0;
            if (bus.out_valid && first < 0) begin
                first = cyc;
                if (stall > 0) begin
                    bus.out_ready = 1'b0;
                    left = stall;
                end
            end else if (left > 0) begin
                left--;
                if (left == 0) bus.out_ready = 1'b1;
            end
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) check("done_timeout", 0, 1);
        check("first_latency", first, N + 2);
        check("done_cycle", done_cyc, N*N*(N+3) + stall);
        check("ovf", bus.ovf, exp_ovf);
        check("sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
        check("done_pulse", bus.done, 0);
        check("busy_idle", bus.busy, 0);
        if (poke) begin
            repeat (10) @(posedge clk);
            #1;
            check("no_second_run", bus.busy | bus.out_valid, 0);
        end
        sb.delete();
    endtask

    initial begin
        bus.we        = 1'b0;
        bus.addr      = '0;
        bus.data_wr   = '0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_state_busy", bus.busy, 0);
        check("rst_state_valid", bus.out_valid, 0);
        check("rst_state_done", bus.done, 0);
        check("rst_state_ovf", bus.ovf, 0);
        check("rst_state_data", bus.out_data, 0);
        check("rst_state_col", bus.out_col, 0);
        check("qi", qi, 8);
        check("qf", qf, 8);

        load(384, 512, -256, 128, 512, 0, 0, 512);
        run(0, 1'b0, -1);
        run(5, 1'b0, -1);
        wr(8, 999);
        run(0, 1'b1, -1);

        load(1, 0, 0, 0, 128, 0, 0, 0);
        run(0, 1'b0, -1);
        wr(0, -1);
        run(0, 1'b0, -1);

        load(32512, 32512, 32512, 32512, 32512, 32512, 32512, 32512);
        run(0, 1'b0, -1);
        wr(0, -32512); wr(1, -32512); wr(2, -32512); wr(3, -32512);
        run(0, 1'b0, -1);
        load(384, 512, -256, 128, 512, 0, 0, 512);
        run(0, 1'b0, -1);

        load(32512, 32512, 32512, 32512, 32512, 32512, 32512, 32512);
        run(0, 1'b0, 7);
        run(0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/matrix_mul_fx_stream.md
Name: matrix_mul_fx_stream

Overview:
Parametrised fixed-point square-matrix multiplier, successor to the fixed Matrix_Mul core. Host loads A and B over a single write port, pulses start, and the block computes C = A·B with one sequential MAC. It streams C in column-major order, i.e. the rows of (A·B)^T, one element per valid/ready beat. Generalises dimension, word width and Q format. Adds rounding, saturation, an overflow flag, a start/done handshake and output backpressure.

Parameters:
N, 4, matrix dimension (2..16)
WORD_SIZE, 16, signed element width in bits
QF_BITS, 8, fractional bits (1..WORD_SIZE-1); QI = WORD_SIZE-QF_BITS
ADDRS_LEN, clog2(2*N*N), write-address width

Ports:
src_clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
we  in  1  write enable for the A/B load port
addr  in  ADDRS_LEN  element address: 0..N*N-1 is A row-major; N*N..2*N*N-1 is B row-major
data_wr  in  WORD_SIZE  signed Q(QI.QF) element
start  in  1  one-cycle pulse, begin computation
busy  out  1  high from the start-accept cycle until the done cycle
done  out  1  one-cycle pulse after the last element transfers
out_valid  out  1  out_data holds a valid element
out_ready  in  1  consumer accepts the element
out_data  out  WORD_SIZE  signed C element in the same Q format
out_row  out  clog2(N)  row index i of out_data
out_col  out  clog2(N)  column index j of out_data
ovf  out  1  sticky; set if any element of the current run saturated
QI  out  4  constant WORD_SIZE-QF_BITS
QF  out  4  constant QF_BITS

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, out_valid, ovf = 0; out_data, out_row, out_col = 0. Memory contents are not reset.
- Writes take effect only in IDLE. In any other state, and at addr >= 2*N*N, writes are ignored.
- Memory: two N*N arrays with synchronous read (1-cycle latency).
- FSM states: IDLE, MAC, ROUND, OUT, DONE.
- IDLE: a start pulse moves to MAC and clears ovf, the accumulator and i=j=0. start is ignored in every other state.
- MAC: issue reads A[i][k], B[k][j] for k = 0..N-1 on consecutive cycles. Each product is accumulated one cycle after its read. The accumulator is signed, 2*WORD_SIZE+clog2(N) bits, with no internal overflow. After the last product accumulates, go to ROUND. MAC lasts N+1 cycles.
- ROUND (1 cycle):
  - r = (acc + 2^(QF_BITS-1)) >>> QF_BITS (round half up, arithmetic shift).
  - Saturate r to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
  - If clamped, set ovf.
  - Register the result into out_data, with out_row=i and out_col=j.
  - Go to OUT with out_valid=1.
- Latency: start accepted at cycle 0 gives the first out_valid at cycle N+2.
- OUT:
  - out_data, out_row and out_col stay stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready, drop out_valid next cycle.
  - Advance i first, then j when i wraps (column-major order).
  - Clear the accumulator and return to MAC, or go to DONE if i=j=N-1.
- Per element: N+3 cycles with out_ready held high; N*N*(N+3) cycles per run.
- DONE: done=1 for one cycle, busy=0, back to IDLE. ovf holds until the next accepted start.
- out_ready is a don't-care when out_valid=0.
- Reset mid-run aborts immediately. Outputs return to reset values; no partial done.
- QI/QF are constant wires.

Test Plan:
- N=2, Q8.8 (16-bit), A={384,512,-256,128}, B={512,0,0,512}, start, out_ready=1 -> beats (row,col,data): (0,0,768), (1,0,-512), (0,1,1024), (1,1,256); done one cycle after the last beat; ovf=0; first out_valid exactly 4 cycles after start.
- Rounding, N=2 Q8.8: A={1,0,0,0}, B={128,0,0,0} -> C[0][0]=1 (acc 128 rounds up); A[0][0]=-1 gives C[0][0]=0; all other elements 0.
- Saturation, N=2: A and B all 32512 (127.0) -> every element 32767 and ovf=1. Negate A -> every element -32768 and ovf=1. A following clean run clears ovf.
- Backpressure: hold out_ready=0 for 5 cycles on the first beat -> out_valid, out_data, out_row and out_col stay stable. The sequence and values are unchanged, and total cycles grow by exactly 5.
- Protocol: writes and start while busy are ignored, so the result equals the pre-start contents and no second run occurs. A write to addr=2*N*N is ignored.
- Async reset: assert rst_n=0 mid-MAC, off the clock edge -> busy, out_valid, ovf and done drop immediately. After release, a new start without reloading reproduces the expected results from the retained memory.
